serial_add_ctrl: RTL and testbench

//   Digit-serial multi-word adder. Accepts WIDTH-bit operands plus carry-in over a valid/ready

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/serial_digit_add.sv | 16 +
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// Pure declarations; no logic.
// No handshake of its own.
package serial_add_pkg;

    localparam int DIGIT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Number of digit steps needed to cover a word.
    function automatic int n_digits(input int width, input int digit = DIGIT_DEFAULT);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_digit_add.sv
// DIGIT-bit combinational adder with carry in/out; the only arithmetic in the block.
// Latency: zero cycles (purely combinational).
// Backpressure: none, the result follows the inputs.
module serial_digit_add #(
    parameter int DIGIT = serial_add_pkg::DIGIT_DEFAULT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// Digit-serial WIDTH-bit adder, LSB digit first; SERIAL_ADD_SUB_EN adds an in_sub (A-B) mode.
// Latency: out_valid rises N = WIDTH/DIGIT cycles after the accepting edge.
// Backpressure: result held while out_ready is low; in_ready only returns after the result handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = DIGIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int N  = n_digits(WIDTH, DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    sa_state_t         state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic [DIGIT-1:0]  d_sum;
    logic              d_cout;
    logic [WIDTH-1:0]  sum_next;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;
    logic              last_digit;

    serial_digit_add #(
        .DIGIT (DIGIT)
    ) u_digit_add (
        .a    (a_sr[DIGIT-1:0]),
        .b    (b_sr[DIGIT-1:0]),
        .cin  (carry),
        .s    (d_sum),
        .cout (d_cout)
    );

    // out_sum doubles as the sum shift register; new digits enter at the MSB end.
    generate
        if (WIDTH > DIGIT) begin : g_multi
            assign sum_next = {d_sum, out_sum[WIDTH-1:DIGIT]};
        end else begin : g_single
            assign sum_next = d_sum;
        end
    endgenerate

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction as A + ~B + 1; a final carry of 1 means no borrow.
    assign b_load     = in_sub ? ~in_b : in_b;
    assign carry_load = in_sub ? 1'b1  : in_cin;
`else
    assign b_load     = in_b;
    assign carry_load = in_cin;
`endif

    assign last_digit = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= in_a;
                        b_sr     <= b_load;
                        carry    <= carry_load;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> DIGIT;
                    b_sr    <= b_sr >> DIGIT;
                    out_sum <= sum_next;
                    carry   <= d_cout;
                    cnt     <= cnt + 1'b1;
                    if (last_digit) begin
                        out_cout  <= d_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // No same-cycle re-accept: in_ready rises only after the result leaves.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed and random operations against an arithmetic reference.
// Honours SERIAL_ADD_SUB_EN when defined.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef SERIAL_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        in_a   = WIDTH'($urandom);
        in_b   = WIDTH'($urandom);
        in_cin = 1'($urandom);
        in_sub = 1'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".in_ready"},  in_ready,  1);
        check_eq({tag, ".out_valid"}, out_valid, 0);
        check_eq({tag, ".out_sum"},   out_sum,   0);
        check_eq({tag, ".out_cout"},  out_cout,  0);
        check_eq({tag, ".busy"},      busy,      0);
    endtask

    // One complete operation: accept, wait for result, optional stall, handshake.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic ci, input logic sb, input int stall);
        int          cyc;
        int          total;
        logic [WIDTH-1:0] exp_sum;
        logic        exp_cout;

        // Reference: plain integer arithmetic on the whole operands.
        if (sb) begin
            exp_sum  = WIDTH'(int'(a) - int'(b));
            exp_cout = (a >= b);
        end else begin
            total    = int'(a) + int'(b) + int'(ci);
            exp_sum  = WIDTH'(total);
            exp_cout = (total >= (1 << WIDTH));
        end

        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        check_eq("idle_ready", in_ready, 1);

        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = ci;
        in_sub   = sb;
        tick();
        check_eq("run_busy",  busy,     1);
        check_eq("run_ready", in_ready, 0);

        // Inputs are ignored outside IDLE, so keep them noisy.
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            in_valid = 1'($urandom);
            scramble_inputs();
            tick();
            cyc++;
        end
        check_eq("latency",  cyc,      N);
        check_eq("sum",      out_sum,  exp_sum);
        check_eq("cout",     out_cout, exp_cout);

        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            scramble_inputs();
            tick();
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_sum",   out_sum,   exp_sum);
            check_eq("stall_cout",  out_cout,  exp_cout);
            check_eq("stall_ready", in_ready,  0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("post_valid", out_valid, 0);
        check_eq("post_ready", in_ready,  1);
        check_eq("post_busy",  busy,      0);
        check_eq("hold_sum",   out_sum,   exp_sum);
        check_eq("hold_cout",  out_cout,  exp_cout);
    endtask

    initial begin
        int cyc;
        logic sb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 5);

        // Abort during the second RUN cycle.
        in_valid = 1'b1;
        in_a     = 8'hC7;
        in_b     = 8'h9E;
        in_cin   = 1'b1;
        in_sub   = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        cyc = 0;
        while (!out_valid && cyc < 8) begin
            tick();
            cyc++;
        end
        check_eq("midrst_no_result", out_valid, 0);
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 1'b1, 0);
        run_op(8'h01, 8'h02, 1'b0, 1'b1, 2);
`endif

        for (int i = 0; i < 24; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), sb,
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
